// File: rtl/ha_array_reducer.sv
// ha_array_reducer: weighted reduction of four HA row pairs into a product.
// Two-stage valid/ready pipe with an optional MAC accumulator in stage 2.
module ha_array_reducer #(
  parameter int OUT_W = 16,
  parameter int ACC_W = 24,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  input  logic             in_acc,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] prod,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int RW = 10;
  localparam int PW = 13;
  localparam int SW = 17;

  typedef struct packed {
    logic [PW-1:0] p01;
    logic [PW-1:0] p23;
    logic          acc;
    logic          clr;
  } s1_t;

  // row value: sum bits at weight 2^k, carry bits two places higher
  function automatic logic [RW-1:0] row_val(
    input logic [8:0] t,
    input logic [6:0] b
  );
    return RW'(t) + {1'b0, b, 2'b00};
  endfunction

  logic [RW-1:0] w_r0;
  logic [RW-1:0] w_r1;
  logic [RW-1:0] w_r2;
  logic [RW-1:0] w_r3;
  logic [PW-1:0] w_p01;
  logic [PW-1:0] w_p23;
  s1_t           w_s1_d;

  s1_t           r_s1;
  logic          r_s1_valid;
  logic          r_s2_valid;
  logic [OUT_W-1:0] r_prod;
  logic [ACC_W-1:0] r_acc;
  logic          r_ovf;

  logic          w_s2_load;
  logic          w_in_fire;
  logic [SW-1:0] w_sum;
  logic [OUT_W-1:0] w_lo;
  logic          w_hi;
  logic [OUT_W-1:0] w_prod;
  logic          w_do_clr;
  logic          w_do_add;
  logic [ACC_W-1:0] w_acc_nxt;

  assign w_r0 = row_val(ha_array_0_t, ha_array_0_b);
  assign w_r1 = row_val(ha_array_1_t, ha_array_1_b);
  assign w_r2 = row_val(ha_array_2_t, ha_array_2_b);
  assign w_r3 = row_val(ha_array_3_t, ha_array_3_b);

  // rows r and r+1 differ by a factor of four
  assign w_p01 = PW'(w_r0) + {1'b0, w_r1, 2'b00};
  assign w_p23 = PW'(w_r2) + {1'b0, w_r3, 2'b00};

  assign w_s1_d = '{
    p01: w_p01,
    p23: w_p23,
    acc: in_acc,
    clr: in_clr
  };

  // S2 loads when S1 has data and S2 is empty or draining
  assign w_s2_load = r_s1_valid & (!r_s2_valid | out_ready);
  assign in_ready  = !r_s1_valid | (!r_s2_valid | out_ready);
  assign w_in_fire = in_valid & in_ready;

  // upper pair sits 2^4 above the lower pair
  assign w_sum = SW'(r_s1.p01) + {r_s1.p23, 4'b0000};

  generate
    if (OUT_W >= SW) begin : g_wide
      assign w_lo = OUT_W'(w_sum);
      assign w_hi = 1'b0;
    end else begin : g_narrow
      assign w_lo = w_sum[OUT_W-1:0];
      assign w_hi = |w_sum[SW-1:OUT_W];
    end
  endgenerate

  assign w_prod = (w_hi && SAT) ? '1 : w_lo;

  // clear wins over accumulate
  assign w_do_clr = r_s1.clr;
  assign w_do_add = r_s1.acc & !r_s1.clr;

  // accumulator next value for the beat entering S2
  always_comb begin
    w_acc_nxt = r_acc;
    unique case (1'b1)
      w_do_clr: w_acc_nxt = ACC_W'(w_prod);
      w_do_add: w_acc_nxt = r_acc + ACC_W'(w_prod);
      default:  w_acc_nxt = r_acc;
    endcase
  end

  // stage 1: partial pair sums plus sideband
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (in_ready)
        r_s1_valid <= in_valid;
      if (w_in_fire)
        r_s1 <= w_s1_d;
    end
  end

  // stage 2: final sum, saturation and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_prod     <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_prod     <= w_prod;
        r_acc      <= w_acc_nxt;
        r_ovf      <= w_hi;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign prod      = r_prod;
  assign acc       = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_ha_array_reducer.sv
// tb_ha_array_reducer: directed checks of the HA array reducer.
// Two instances run in lockstep: saturating and wrapping.
module tb_ha_array_reducer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        in_acc;
  logic        in_clr;
  logic [35:0] tv;
  logic [27:0] bv;

  logic        ir1, ov1, of1;
  logic [15:0] prod1;
  logic [23:0] acc1;
  logic        ir0, ov0, of0;
  logic [15:0] prod0;
  logic [23:0] acc0;

  int n_chk = 0;
  int n_err = 0;

  ha_array_reducer #(.OUT_W(16), .ACC_W(24), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir1),
    .ha_array_0_b(bv[6:0]),   .ha_array_1_b(bv[13:7]),
    .ha_array_2_b(bv[20:14]), .ha_array_3_b(bv[27:21]),
    .ha_array_0_t(tv[8:0]),   .ha_array_1_t(tv[17:9]),
    .ha_array_2_t(tv[26:18]), .ha_array_3_t(tv[35:27]),
    .in_acc(in_acc), .in_clr(in_clr),
    .out_valid(ov1), .out_ready(out_ready),
    .prod(prod1), .acc(acc1), .ovf(of1)
  );

  ha_array_reducer #(.OUT_W(16), .ACC_W(24), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir0),
    .ha_array_0_b(bv[6:0]),   .ha_array_1_b(bv[13:7]),
    .ha_array_2_b(bv[20:14]), .ha_array_3_b(bv[27:21]),
    .ha_array_0_t(tv[8:0]),   .ha_array_1_t(tv[17:9]),
    .ha_array_2_t(tv[26:18]), .ha_array_3_t(tv[35:27]),
    .in_acc(in_acc), .in_clr(in_clr),
    .out_valid(ov0), .out_ready(out_ready),
    .prod(prod0), .acc(acc0), .ovf(of0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one beat through an empty pipe, checked two edges later
  task automatic send(
    input string       tag,
    input logic [35:0] t,
    input logic [27:0] b,
    input logic        a,
    input logic        c,
    input logic [15:0] ep1,
    input logic [15:0] ep0,
    input logic [23:0] ea,
    input logic        eo
  );
    @(negedge clk);
    tv = t; bv = b; in_acc = a; in_clr = c;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_ir"}, ir1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, ov1, 1'b0);
    @(negedge clk);
    check({tag, "_vld"},   ov1,   1'b1);
    check({tag, "_prod"},  prod1, ep1);
    check({tag, "_prodw"}, prod0, ep0);
    check({tag, "_acc"},   acc1,  ea);
    check({tag, "_accw"},  acc0,  ea);
    check({tag, "_ovf"},   of1,   eo);
    check({tag, "_ovfw"},  of0,   eo);
  endtask

  logic [8:0]  bp_t  [4];
  logic [15:0] exp_bp[4];

  initial begin
    int  tx, rx, cyc;
    logic fx;
    bp_t   = '{9'd17, 9'd20, 9'd23, 9'd26};
    exp_bp = '{16'd17, 16'd20, 16'd23, 16'd26};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_acc = 1'b0; in_clr = 1'b0; tv = '0; bv = '0;
    #12;
    check("rst_vld",  ov1,   1'b0);
    check("rst_prod", prod1, 16'h0);
    check("rst_acc",  acc1,  24'h0);
    check("rst_ovf",  of1,   1'b0);
    check("rst_ir",   ir1,   1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    send("zero", 36'h0, 28'h0, 1'b0, 1'b1,
         16'h0, 16'h0, 24'h0, 1'b0);
    send("t1ff", {4{9'h1FF}}, 28'h0, 1'b0, 1'b1,
         16'hA9AB, 16'hA9AB, 24'h00A9AB, 1'b0);
    send("t1ff_acc", {4{9'h1FF}}, 28'h0, 1'b1, 1'b0,
         16'hA9AB, 16'hA9AB, 24'h015356, 1'b0);
    send("ones", {4{9'h1FF}}, {4{7'h7F}}, 1'b0, 1'b0,
         16'hFFFF, 16'h5257, 24'h015356, 1'b1);
    send("ld100", {27'd0, 9'd100}, 28'h0, 1'b0, 1'b1,
         16'd100, 16'd100, 24'd100, 1'b0);
    send("clrpri", {27'd0, 9'd5}, 28'h0, 1'b1, 1'b1,
         16'd5, 16'd5, 24'd5, 1'b0);
    // b row of row 1 only: weight 2^(2+0+2) per bit
    send("brow1", 36'h0, {14'd0, 7'd1, 7'd0}, 1'b1, 1'b0,
         16'd16, 16'd16, 24'd21, 1'b0);

    // backpressure: four beats, three stalled cycles
    tx = 0; rx = 0; cyc = 0;
    while (rx < 4 && cyc < 30) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (tx < 4);
      if (tx < 4) tv = {27'd0, bp_t[tx]};
      bv = '0; in_clr = 1'b1; in_acc = 1'b0;
      #1;
      if (cyc == 2) begin
        check("bp_stall_ir", ir1, 1'b0);
        check("bp_held", tx, 2);
      end
      if (ov1) begin
        check("bp_prod", prod1, exp_bp[rx]);
        check("bp_acc",  acc1,  24'(exp_bp[rx]));
        if (out_ready) rx++;
      end
      fx = in_valid && ir1;
      @(posedge clk);
      if (fx) tx++;
      cyc++;
    end
    check("bp_count", rx, 4);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 check("bp_drained", ov1, 1'b0);

    // reset with both stages full
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_clr = 1'b1;
    tv = {27'd0, 9'd7};
    @(negedge clk);
    tv = {27'd0, 9'd9};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mid_full_vld", ov1,  1'b1);
    check("mid_full_acc", acc1, 24'd7);
    check("mid_full_ir",  ir1,  1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld",  ov1,   1'b0);
    check("mid_rst_acc",  acc1,  24'd0);
    check("mid_rst_prod", prod1, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send("post_rst", {27'd0, 9'd3}, 28'h0, 1'b1, 1'b0,
         16'd3, 16'd3, 24'd3, 1'b0);
    @(negedge clk);
    check("post_rst_alone", ov1, 1'b0);
    @(negedge clk);
    check("post_rst_idle", ov1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
